rgb_stream_arbiter: RTL and testbench

- Two-input, one-output arbiter for 8-bit-per-channel RGB pixel streams (r/g/b composite) with valid/ready handshake and a line-end `last` marker.
- Shares one downstream pixel path between two sources: round-robin grant, held for a whole line, released on the accepted `last` beat.
- Single registered output stage gives 1-cycle latency.
- Sits between pixel producers (e.g. video source and overlay/test-pattern generator) and the pixel sink.

---
 rtl/rgb_stream_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rgb_stream_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_arbiter.sv
// Two-source RGB pixel stream arbiter: round-robin grant held for a whole line, one registered output stage.
// Optional mid-line stall timeout is built only when RGB_STREAM_ARBITER_TIMEOUT_EN is defined.
module rgb_stream_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_0_r,
    input  logic [7:0] in_0_g,
    input  logic [7:0] in_0_b,
    input  logic       in_0_last,
    input  logic       in_0_valid,
    output logic       in_0_ready,
    input  logic [7:0] in_1_r,
    input  logic [7:0] in_1_g,
    input  logic [7:0] in_1_b,
    input  logic       in_1_last,
    input  logic       in_1_valid,
    output logic       in_1_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] grant,
    output logic       timeout_err
);

    // State codes double as the one-hot grant encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("rgb_stream_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t     state_r;
    state_t     state_next_s;
    logic       last_served_r;
    logic [1:0] grant_r;
    logic [7:0] out_r_r;
    logic [7:0] out_g_r;
    logic [7:0] out_b_r;
    logic       out_last_r;
    logic       out_valid_r;
    logic       load_s;
    logic       acc0_s;
    logic       acc1_s;
    logic       acc_s;
    logic       timeout_s;

    assign load_s     = !out_valid_r || out_ready;
    assign in_0_ready = (state_r == GRANT0) && load_s;
    assign in_1_ready = (state_r == GRANT1) && load_s;
    assign acc0_s     = in_0_valid && in_0_ready;
    assign acc1_s     = in_1_valid && in_1_ready;
    assign acc_s      = acc0_s || acc1_s;

`ifdef RGB_STREAM_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_r;
    logic        stall_s;
    logic        timeout_err_r;

    // Only a missing source pixel counts as a stall; sink backpressure does not.
    assign stall_s   = ((state_r == GRANT0) && !in_0_valid) ||
                       ((state_r == GRANT1) && !in_1_valid);
    assign timeout_s = stall_s && (tmo_cnt_r == TMO_LAST);

    // Stall counter: zero in IDLE so every grant starts fresh, cleared by any accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == IDLE || acc_s || timeout_s) begin
            tmo_cnt_r <= 16'd0;
        end else if (stall_s && tmo_cnt_r < TMO_LAST) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // One-cycle revocation pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_s;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_s   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-owner decision: ties in IDLE go to the source not served last.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_0_valid && in_1_valid) begin
                    state_next_s = last_served_r ? GRANT0 : GRANT1;
                end else if (in_0_valid) begin
                    state_next_s = GRANT0;
                end else if (in_1_valid) begin
                    state_next_s = GRANT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT0: begin
                if ((acc0_s && in_0_last) || timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GRANT0;
                end
            end
            GRANT1: begin
                if ((acc1_s && in_1_last) || timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GRANT1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Ownership, grant mirror and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            grant_r       <= 2'b00;
            last_served_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            grant_r <= state_next_s;
            if (state_r == GRANT0 && state_next_s == IDLE) begin
                last_served_r <= 1'b0;
            end else if (state_r == GRANT1 && state_next_s == IDLE) begin
                last_served_r <= 1'b1;
            end else begin
                last_served_r <= last_served_r;
            end
        end
    end

    // Output register: capture on an accepted beat, drop valid once consumed, data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r_r     <= 8'd0;
            out_g_r     <= 8'd0;
            out_b_r     <= 8'd0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (acc_s) begin
            out_r_r     <= acc1_s ? in_1_r    : in_0_r;
            out_g_r     <= acc1_s ? in_1_g    : in_0_g;
            out_b_r     <= acc1_s ? in_1_b    : in_0_b;
            out_last_r  <= acc1_s ? in_1_last : in_0_last;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_r     = out_r_r;
    assign out_g     = out_g_r;
    assign out_b     = out_b_r;
    assign out_last  = out_last_r;
    assign out_valid = out_valid_r;
    assign grant     = grant_r;

endmodule

// File: tb/tb_rgb_stream_arbiter.sv
// Self-checking bench for rgb_stream_arbiter: vector table, directed corner sequences, random traffic vs model.
module tb_rgb_stream_arbiter;

    localparam int TMO = 8;
`ifdef RGB_STREAM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_0_r = 8'd0, in_0_g = 8'd0, in_0_b = 8'd0;
    logic       in_0_last = 1'b0, in_0_valid = 1'b0, in_0_ready;
    logic [7:0] in_1_r = 8'd0, in_1_g = 8'd0, in_1_b = 8'd0;
    logic       in_1_last = 1'b0, in_1_valid = 1'b0, in_1_ready;
    logic [7:0] out_r, out_g, out_b;
    logic       out_last, out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_stream_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_0_r(in_0_r), .in_0_g(in_0_g), .in_0_b(in_0_b),
        .in_0_last(in_0_last), .in_0_valid(in_0_valid), .in_0_ready(in_0_ready),
        .in_1_r(in_1_r), .in_1_g(in_1_g), .in_1_b(in_1_b),
        .in_1_last(in_1_last), .in_1_valid(in_1_valid), .in_1_ready(in_1_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       v0, l0;
        logic [7:0] r0;
        logic       v1, l1;
        logic [7:0] r1;
        logic       ordy;
        logic [1:0] grant;
        logic       ov;
        logic [7:0] orr;
        logic       olast;
        logic       rdy0, rdy1;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic v0, input logic l0, input logic [7:0] r0,
                                input logic v1, input logic l1, input logic [7:0] r1,
                                input logic ordy, input logic [1:0] g, input logic ov,
                                input logic [7:0] orr, input logic olast,
                                input logic rdy0, input logic rdy1);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.r0 = r0; v.v1 = v1; v.l1 = l1; v.r1 = r1;
        v.ordy = ordy; v.grant = g; v.ov = ov; v.orr = orr; v.olast = olast;
        v.rdy0 = rdy0; v.rdy1 = rdy1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic l0, input logic [7:0] r0,
                         input logic v1, input logic l1, input logic [7:0] r1, input logic ordy);
        in_0_valid = v0; in_0_last = l0; in_0_r = r0; in_0_g = r0; in_0_b = ~r0;
        in_1_valid = v1; in_1_last = l1; in_1_r = r1; in_1_g = r1; in_1_b = ~r1;
        out_ready  = ordy;
    endtask

    // Random-phase reference: owner -1/0/1, stall count, and a one-deep output slot.
    int         m_owner, m_last, m_stall;
    logic       m_ov, m_ol, m_terr;
    logic [7:0] m_r, m_g, m_b;
    logic       dv[2], dl[2], acc_prev[2];
    logic [7:0] dr[2], dg[2], db[2];

    initial begin
        int eg, c0, c1, idx, nout, acc;
        logic ordy, load;

        tbl[0]  = mk(1,0,8'h01, 0,0,8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1,0,8'h01, 0,0,8'h00, 1, 2'b01, 0, 8'h00, 0, 1, 0);
        tbl[2]  = mk(1,0,8'h02, 0,0,8'h00, 1, 2'b01, 1, 8'h01, 0, 1, 0);
        tbl[3]  = mk(1,0,8'h03, 0,0,8'h00, 1, 2'b01, 1, 8'h02, 0, 1, 0);
        tbl[4]  = mk(1,1,8'h04, 0,0,8'h00, 1, 2'b01, 1, 8'h03, 0, 1, 0);
        tbl[5]  = mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00, 1, 8'h04, 1, 0, 0);
        tbl[6]  = mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00, 0, 8'h04, 1, 0, 0);
        tbl[7]  = mk(0,0,8'h00, 1,1,8'h55, 1, 2'b00, 0, 8'h04, 1, 0, 0);
        tbl[8]  = mk(0,0,8'h00, 1,1,8'h55, 1, 2'b10, 0, 8'h04, 1, 0, 1);
        tbl[9]  = mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00, 1, 8'h55, 1, 0, 0);
        tbl[10] = mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00, 0, 8'h55, 1, 0, 0);
        tbl[11] = mk(1,1,8'h10, 1,1,8'h20, 1, 2'b00, 0, 8'h55, 1, 0, 0);
        tbl[12] = mk(1,1,8'h10, 1,1,8'h20, 1, 2'b01, 0, 8'h55, 1, 1, 0);
        tbl[13] = mk(1,1,8'h10, 1,1,8'h20, 1, 2'b00, 1, 8'h10, 1, 0, 0);
        tbl[14] = mk(1,1,8'h10, 1,1,8'h20, 1, 2'b10, 0, 8'h10, 1, 0, 1);
        tbl[15] = mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00, 1, 8'h20, 1, 0, 0);
        tbl[16] = mk(0,0,8'h00, 0,0,8'h00, 1, 2'b00, 0, 8'h20, 1, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_out_rgb", {out_r, out_g, out_b}, 24'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: 4-pixel line, single-beat line, round-robin tie
        for (int i = 0; i < 17; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].v0, tbl[i].l0, tbl[i].r0, tbl[i].v1, tbl[i].l1, tbl[i].r1, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_out_r", i), out_r, tbl[i].orr);
            chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].olast);
            chk($sformatf("tbl%0d_in_0_ready", i), in_0_ready, tbl[i].rdy0);
            chk($sformatf("tbl%0d_in_1_ready", i), in_1_ready, tbl[i].rdy1);
        end

        // Both sources stream continuous 2-pixel lines
        c0 = 0; c1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(1'b1, c0[0], 8'h10, 1'b1, c1[0], 8'h20, 1'b1);
            #1;
            eg = (k % 3 == 0) ? 0 : (((k / 3) % 2 == 0) ? 1 : 2);
            chk($sformatf("rr%0d_grant", k), grant, eg);
            if (eg == 1) chk($sformatf("rr%0d_in_1_ready", k), in_1_ready, 1'b0);
            if (k >= 1 && (k - 1) % 3 != 0) begin
                chk($sformatf("rr%0d_out_valid", k), out_valid, 1'b1);
                chk($sformatf("rr%0d_out_r", k), out_r, (((k - 1) / 3) % 2 == 0) ? 8'h10 : 8'h20);
            end
            if (in_0_ready) c0++;
            if (in_1_ready) c1++;
        end
        repeat (2) begin
            @(negedge clk);
            drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
        end

        // Sink backpressure for 3 cycles mid-line
        idx = 0; nout = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            ordy = !(cyc >= 4 && cyc <= 6);
            drive(idx < 5, idx == 4, 8'(8'h31 + idx), 0, 0, 8'h00, ordy);
            #1;
            if (!ordy) begin
                chk("bp_stall_valid", out_valid, 1'b1);
                chk("bp_stall_ready", in_0_ready, 1'b0);
                chk("bp_stall_data", out_r, 8'(8'h31 + nout));
            end
            if (out_valid && out_ready) begin
                chk("bp_data", out_r, 8'(8'h31 + nout));
                nout++;
            end
            if (in_0_valid && in_0_ready) idx++;
        end
        chk("bp_count", nout, 5);

        // Source 0 stalls after 2 pixels while source 1 waits
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            drive(c < 3, 1'b0, 8'(8'h40 + c), c >= 3, 1'b0, 8'h77, 1'b1);
            #1;
            if (c >= 1) begin
                if (!TO_EN) eg = 1;
                else eg = (c <= 10) ? 1 : ((c == 11) ? 0 : 2);
                chk($sformatf("tmo%0d_grant", c), grant, eg);
            end
            chk($sformatf("tmo%0d_err", c), timeout_err, TO_EN && c == 11);
        end

        // Asynchronous reset mid-line
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h66, in_1_valid, 1'b0, 8'h77, 1'b1);
        @(negedge clk);
        #1;
        chk("prerst_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_grant", grant, 2'b00);
        chk("arst_out_rgb", {out_r, out_g, out_b}, 24'h0);
        chk("arst_ready", {in_0_ready, in_1_ready}, 2'b00);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 8'h82, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_grant0", grant, 2'b00);
        @(negedge clk);
        #1;
        chk("post_rst_grant1", grant, 2'b01);
        chk("post_rst_in_1_ready", in_1_ready, 1'b0);

        // Random traffic against the reference model
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        m_owner = -1; m_last = 1; m_stall = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_terr = 1'b0; m_r = 8'h0; m_g = 8'h0; m_b = 8'h0;
        for (int s = 0; s < 2; s++) begin
            dv[s] = 1'b0; dl[s] = 1'b0; acc_prev[s] = 1'b0;
            dr[s] = 8'h0; dg[s] = 8'h0; db[s] = 8'h0;
        end
        for (int n = 0; n < 2000; n++) begin
            if (n > 0) @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (!dv[s] || acc_prev[s]) begin
                    dv[s] = ($urandom_range(3) != 0);
                    dl[s] = ($urandom_range(3) == 0);
                    dr[s] = 8'($urandom); dg[s] = 8'($urandom); db[s] = 8'($urandom);
                end
            end
            ordy = ($urandom_range(3) != 0);
            in_0_valid = dv[0]; in_0_last = dl[0]; in_0_r = dr[0]; in_0_g = dg[0]; in_0_b = db[0];
            in_1_valid = dv[1]; in_1_last = dl[1]; in_1_r = dr[1]; in_1_g = dg[1]; in_1_b = db[1];
            out_ready = ordy;
            #1;
            load = !m_ov || ordy;
            chk("rnd_grant", grant, (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00));
            chk("rnd_ready", {in_1_ready, in_0_ready}, {m_owner == 1 && load, m_owner == 0 && load});
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_out_pix", {out_last, out_r, out_g, out_b}, {m_ol, m_r, m_g, m_b});
            chk("rnd_timeout_err", timeout_err, m_terr);

            acc = -1;
            if (m_owner >= 0) begin
                if (dv[m_owner] && load) acc = m_owner;
            end
            acc_prev[0] = (acc == 0);
            acc_prev[1] = (acc == 1);
            m_terr = 1'b0;
            if (acc >= 0) begin
                m_ov = 1'b1; m_r = dr[acc]; m_g = dg[acc]; m_b = db[acc]; m_ol = dl[acc];
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (m_owner < 0) begin
                if (dv[0] && dv[1]) m_owner = 1 - m_last;
                else if (dv[0]) m_owner = 0;
                else if (dv[1]) m_owner = 1;
                m_stall = 0;
            end else if (acc >= 0) begin
                m_stall = 0;
                if (dl[acc]) begin
                    m_last = acc;
                    m_owner = -1;
                end
            end else if (!dv[m_owner]) begin
                m_stall++;
                if (TO_EN && m_stall == TMO) begin
                    m_terr = 1'b1;
                    m_last = m_owner;
                    m_owner = -1;
                    m_stall = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
